// File: rtl/note_scroller.sv
// Chart prefetch and beat-driven scroll index for the LED note display.
// Single-entry prefetch buffer; a bar boundary with an empty buffer plays a blank bar.
module note_scroller #(
  parameter int SONG_LEN = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        mode,
  input  logic              beat_tick,
  output logic              chart_req,
  output logic [ADDR_W-1:0] chart_addr,
  input  logic              chart_ack,
  input  logic [31:0]       chart_note1,
  input  logic [31:0]       chart_note2,
  output logic [31:0]       next_note1,
  output logic [31:0]       next_note2,
  output logic [4:0]        next_idx1,
  output logic [4:0]        next_idx2,
  output logic              underrun,
  output logic              song_done
);
  // One extra bit so the fetch counter can reach SONG_LEN when SONG_LEN == 2**ADDR_W.
  localparam int CW = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, PRIME, PLAY, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] active1_q, active1_d, active2_q, active2_d;
  logic [31:0] buf1_q, buf1_d, buf2_q, buf2_d;
  logic        buf_valid_q, buf_valid_d;
  logic [4:0]  idx_q, idx_d;
  logic [CW-1:0] fetch_addr_q, fetch_addr_d;
  logic [CW-1:0] bars_left_q, bars_left_d;
  logic        req_q, req_d;
  logic        underrun_q, underrun_d;
  logic        play, ack_ok;

  assign play   = (mode == 3'd2);
  assign ack_ok = chart_ack && req_q;

  always_comb begin
    state_d      = state_q;
    active1_d    = active1_q;
    active2_d    = active2_q;
    buf1_d       = buf1_q;
    buf2_d       = buf2_q;
    buf_valid_d  = buf_valid_q;
    idx_d        = idx_q;
    fetch_addr_d = fetch_addr_q;
    bars_left_d  = bars_left_q;
    req_d        = req_q;
    underrun_d   = underrun_q;

    if (ack_ok && (state_q == PRIME || state_q == PLAY)) begin
      buf1_d       = chart_note1;
      buf2_d       = chart_note2;
      buf_valid_d  = 1'b1;
      req_d        = 1'b0;
      fetch_addr_d = fetch_addr_q + CW'(1);
    end

    case (state_q)
      IDLE: if (play) begin
        underrun_d = 1'b0;
        req_d      = 1'b1;
        state_d    = PRIME;
      end
      PRIME: if (buf_valid_q) begin
        active1_d   = buf1_q;
        active2_d   = buf2_q;
        buf_valid_d = 1'b0;
        idx_d       = 5'd0;
        req_d       = 1'b1;
        bars_left_d = CW'(SONG_LEN - 1);
        state_d     = PLAY;
      end
      PLAY: if (beat_tick) begin
        if (idx_q != 5'd31) begin
          idx_d = idx_q + 5'd1;
        end else if (bars_left_q == '0) begin
          active1_d   = '0;
          active2_d   = '0;
          idx_d       = 5'd0;
          req_d       = 1'b0;
          buf_valid_d = 1'b0;
          state_d     = DONE;
        end else begin
          // Registered buf_valid only: a same-cycle ack lands in the buffer for the next bar.
          idx_d       = 5'd0;
          bars_left_d = bars_left_q - CW'(1);
          if (buf_valid_q) begin
            active1_d   = buf1_q;
            active2_d   = buf2_q;
            buf_valid_d = 1'b0;
            if (fetch_addr_q < CW'(SONG_LEN)) req_d = 1'b1;
          end else begin
            active1_d  = '0;
            active2_d  = '0;
            underrun_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Leaving play mode aborts from anywhere; underrun stays visible to the controller.
    if (!play && state_q != IDLE) begin
      state_d      = IDLE;
      active1_d    = '0;
      active2_d    = '0;
      buf1_d       = '0;
      buf2_d       = '0;
      buf_valid_d  = 1'b0;
      idx_d        = 5'd0;
      fetch_addr_d = '0;
      bars_left_d  = '0;
      req_d        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      active1_q    <= '0;
      active2_q    <= '0;
      buf1_q       <= '0;
      buf2_q       <= '0;
      buf_valid_q  <= 1'b0;
      idx_q        <= 5'd0;
      fetch_addr_q <= '0;
      bars_left_q  <= '0;
      req_q        <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      active1_q    <= active1_d;
      active2_q    <= active2_d;
      buf1_q       <= buf1_d;
      buf2_q       <= buf2_d;
      buf_valid_q  <= buf_valid_d;
      idx_q        <= idx_d;
      fetch_addr_q <= fetch_addr_d;
      bars_left_q  <= bars_left_d;
      req_q        <= req_d;
      underrun_q   <= underrun_d;
    end
  end

  assign chart_req  = req_q;
  assign chart_addr = fetch_addr_q[ADDR_W-1:0];
  assign next_note1 = active1_q;
  assign next_note2 = active2_q;
  assign next_idx1  = idx_q;
  assign next_idx2  = idx_q;
  assign underrun   = underrun_q;
  assign song_done  = (state_q == DONE);
endmodule

// File: tb/tb_note_scroller.sv
// Scoreboard bench: stimulus queues each expected output change, a monitor pops on every change.
module tb_note_scroller;
  localparam int SL = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst, beat_tick, chart_req, chart_ack;
  logic [2:0]    mode;
  logic [AW-1:0] chart_addr;
  logic [31:0]   chart_note1, chart_note2, next_note1, next_note2;
  logic [4:0]    next_idx1, next_idx2;
  logic          underrun, song_done;

  always #5 clk = ~clk;

  note_scroller #(.SONG_LEN(SL), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .beat_tick(beat_tick),
    .chart_req(chart_req), .chart_addr(chart_addr), .chart_ack(chart_ack),
    .chart_note1(chart_note1), .chart_note2(chart_note2),
    .next_note1(next_note1), .next_note2(next_note2),
    .next_idx1(next_idx1), .next_idx2(next_idx2),
    .underrun(underrun), .song_done(song_done)
  );

  typedef struct packed {
    logic [31:0] n1, n2;
    logic [4:0]  i1, i2;
    logic        und, done;
  } obs_t;

  obs_t        expq[$];
  obs_t        m;
  int          m_bar;
  logic [31:0] w1[SL], w2[SL], s1[SL], s2[SL];
  bit          su[SL];
  int          n_pass = 0, n_total = 0;
  int          hold_addr = -1;
  bit          force_ack = 1'b0;

  function automatic obs_t cur();
    return {next_note1, next_note2, next_idx1, next_idx2, underrun, song_done};
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Chart memory: 2-cycle ack latency, optional hold of one address, forced ack on demand.
  initial begin
    int cnt;
    cnt = 0;
    chart_ack = 1'b0; chart_note1 = '0; chart_note2 = '0;
    forever begin
      @(negedge clk); #1;
      if (force_ack) begin
        chart_ack   = 1'b1;
        chart_note1 = chart_req ? w1[chart_addr] : 32'hDEAD_BEEF;
        chart_note2 = chart_req ? w2[chart_addr] : 32'hDEAD_BEEF;
      end else if (!chart_req) begin
        cnt = 0; chart_ack = 1'b0;
      end else begin
        cnt++;
        if (cnt >= 2 && int'(chart_addr) != hold_addr) begin
          chart_ack   = 1'b1;
          chart_note1 = w1[chart_addr];
          chart_note2 = w2[chart_addr];
        end else chart_ack = 1'b0;
      end
    end
  end

  initial begin
    obs_t prev, o, e;
    @(negedge clk);
    wait (rst == 1'b0);
    prev = cur();
    forever begin
      @(negedge clk);
      o = cur();
      if (o != prev) begin
        n_total++;
        if (expq.size() == 0) begin
          $display("FAIL event: unexpected change n1=%h n2=%h idx=%0d/%0d und=%b done=%b",
                   o.n1, o.n2, o.i1, o.i2, o.und, o.done);
        end else begin
          e = expq.pop_front();
          if (o == e) n_pass++;
          else $display("FAIL event: got n1=%h n2=%h idx=%0d/%0d und=%b done=%b want n1=%h n2=%h idx=%0d/%0d und=%b done=%b",
                        o.n1, o.n2, o.i1, o.i2, o.und, o.done, e.n1, e.n2, e.i1, e.i2, e.und, e.done);
        end
        prev = o;
      end
    end
  end

  task automatic set_sched(input int blank_bar);
    for (int k = 0; k < SL; k++) begin
      su[k] = (k == blank_bar);
      if (blank_bar < 0 || k < blank_bar) begin s1[k] = w1[k]; s2[k] = w2[k]; end
      else if (k == blank_bar) begin s1[k] = '0; s2[k] = '0; end
      else begin s1[k] = w1[k-1]; s2[k] = w2[k-1]; end
    end
  endtask

  task automatic push_start();
    m.n1 = s1[0]; m.n2 = s2[0]; m.i1 = 5'd0; m.i2 = 5'd0; m.done = 1'b0;
    m_bar = 0;
    expq.push_back(m);
  endtask

  task automatic push_idle();
    m.n1 = '0; m.n2 = '0; m.i1 = 5'd0; m.i2 = 5'd0; m.done = 1'b0;
    expq.push_back(m);
  endtask

  task automatic model_tick();
    if (m.i1 != 5'd31) begin
      m.i1 = m.i1 + 5'd1; m.i2 = m.i2 + 5'd1;
    end else if (m_bar == SL - 1) begin
      m.n1 = '0; m.n2 = '0; m.i1 = 5'd0; m.i2 = 5'd0; m.done = 1'b1;
    end else begin
      m_bar++;
      m.i1 = 5'd0; m.i2 = 5'd0; m.n1 = s1[m_bar]; m.n2 = s2[m_bar];
      if (su[m_bar]) m.und = 1'b1;
    end
    expq.push_back(m);
  endtask

  task automatic tick_run(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); beat_tick = 1'b1; model_tick();
      if (gap > 1) begin
        @(negedge clk); beat_tick = 1'b0;
        repeat (gap - 2) @(negedge clk);
      end
    end
    @(negedge clk); beat_tick = 1'b0;
  endtask

  task automatic wait_play();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (next_note1 == s1[0] && next_note2 == s2[0]) begin ok = 1'b1; break; end
    end
    chk(ok, "enter_play", next_note1, s1[0]);
  endtask

  task automatic enter_mode2();
    @(negedge clk); mode = 3'd2; push_start();
  endtask

  task automatic leave_mode2();
    @(negedge clk); mode = 3'd0; push_idle();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < SL; k++) begin
      w1[k] = 32'hA000_0001 + k;
      w2[k] = 32'hB000_0010 + k;
    end
    m = '0;
    rst = 1'b1; mode = 3'd0; beat_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk(next_note1 == 0, "rst_note1", next_note1, 0);
    chk(next_note2 == 0, "rst_note2", next_note2, 0);
    chk(next_idx1 == 0 && next_idx2 == 0, "rst_idx", {27'd0, next_idx1}, 0);
    chk(chart_req == 0, "rst_req", {31'd0, chart_req}, 0);
    chk(underrun == 0, "rst_underrun", {31'd0, underrun}, 0);
    chk(song_done == 0, "rst_done", {31'd0, song_done}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Normal song, tick every 4 cycles.
    set_sched(-1);
    enter_mode2();
    wait_play();
    tick_run(SL * 32, 4);
    chk(song_done == 1, "normal_done", {31'd0, song_done}, 1);
    leave_mode2();

    // Word 2 withheld past the bar-1 boundary.
    set_sched(2);
    hold_addr = 2;
    enter_mode2();
    wait_play();
    tick_run(64, 4);
    hold_addr = -1;
    tick_run(64, 4);
    chk(underrun == 1, "underrun_sticky", {31'd0, underrun}, 1);
    leave_mode2();

    // Ticks in PRIME ignored, consecutive ticks, then reset at idx 9 with a tick.
    set_sched(-1);
    hold_addr = 0;
    @(negedge clk); mode = 3'd2;
    m.und = 1'b0; expq.push_back(m);
    repeat (3) begin
      @(negedge clk); beat_tick = 1'b1;
      @(negedge clk); beat_tick = 1'b0;
    end
    push_start();
    hold_addr = -1;
    wait_play();
    tick_run(9, 1);
    @(negedge clk); rst = 1'b1; beat_tick = 1'b1;
    m.und = 1'b0; push_idle();
    @(negedge clk); rst = 1'b0; beat_tick = 1'b0; mode = 3'd0;
    chk(chart_req == 0, "reset_req", {31'd0, chart_req}, 0);
    chk(song_done == 0, "reset_done", {31'd0, song_done}, 0);
    repeat (2) @(negedge clk);

    // Abort at idx 17 of bar 1 with a fetch outstanding; stray ack afterwards.
    set_sched(-1);
    hold_addr = 2;
    enter_mode2();
    wait_play();
    tick_run(32 + 17, 4);
    chk(chart_req == 1, "abort_req_pending", {31'd0, chart_req}, 1);
    @(negedge clk); mode = 3'd0; push_idle();
    @(negedge clk);
    chk(chart_req == 0, "abort_req_drop", {31'd0, chart_req}, 0);
    force_ack = 1'b1;
    @(negedge clk); force_ack = 1'b0; hold_addr = 0;
    repeat (2) @(negedge clk);
    enter_mode2();
    @(negedge clk);
    chk(chart_req == 1 && chart_addr == 0, "restart_addr", {30'd0, chart_addr}, 0);
    hold_addr = -1;
    wait_play();
    tick_run(5, 4);
    leave_mode2();

    // Ack of word 1 coincides with the wrapping tick of bar 0.
    set_sched(1);
    hold_addr = 1;
    enter_mode2();
    wait_play();
    tick_run(31, 4);
    @(negedge clk); beat_tick = 1'b1; force_ack = 1'b1; hold_addr = -1; model_tick();
    @(negedge clk); beat_tick = 1'b0; force_ack = 1'b0;
    tick_run(96, 4);
    chk(underrun == 1 && song_done == 1, "collision_end", {30'd0, underrun, song_done}, 3);
    leave_mode2();

    repeat (5) @(negedge clk);
    chk(expq.size() == 0, "queue_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
